// File: rtl/wb_unit_pkg.sv
// Shared CPU definitions: register-file geometry and the write-request record
// used by the register file and the writeback unit.
package wb_unit_pkg;

  localparam int CPU_DW = 32;
  localparam int CPU_AW = 4;

  typedef struct packed {
    logic [CPU_AW-1:0] rd;
    logic              hl;
    logic [CPU_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/wb_lq.sv
// Load-return FIFO: synchronous, head visible the cycle after push.
// A push while full is taken only when a pop happens in the same cycle.
module wb_lq #(
  parameter int  W     = 8,
  parameter int  DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback arbiter: ALU beats the load queue; winner drives the RF one cycle later.
// Loads back-pressure via ld_ready when the queue is full and not draining; pend tracks outstanding loads.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int DW       = CPU_DW,
  parameter int AW       = CPU_AW,
  parameter int LQ_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [AW-1:0]         alu_rd,
  input  logic                  alu_hl,
  input  logic [DW-1:0]         alu_data,
  input  logic                  ld_valid,
  input  logic [AW-1:0]         ld_rd,
  input  logic                  ld_hl,
  input  logic [DW-1:0]         ld_data,
  output logic                  ld_ready,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  iss_hl,
  output logic                  we,
  output logic [AW-1:0]         write_reg,
  output logic                  RF_HL,
  output logic [DW-1:0]         data_in,
  output logic [2*(2**AW)-1:0]  pend,
  output logic [1:0]            lq_cnt
);

  localparam int CW = $clog2(LQ_DEPTH + 1);

  wr_req_t       ld_req;
  wr_req_t       head;
  logic          lq_empty;
  logic          lq_full;
  logic          lq_pop;
  logic          ld_fire;
  logic [CW-1:0] cnt;

  assign ld_req   = '{rd: ld_rd, hl: ld_hl, data: ld_data};
  assign lq_pop   = !alu_valid && !lq_empty;
  // A full queue still accepts when its head leaves this same cycle.
  assign ld_ready = !lq_full || lq_pop;
  assign ld_fire  = ld_valid && ld_ready;
  assign lq_cnt   = 2'(cnt);

  wb_lq #(
    .W     ($bits(wr_req_t)),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk   (clk),
    .reset (reset),
    .push  (ld_fire),
    .din   (ld_req),
    .pop   (lq_pop),
    .dout  (head),
    .empty (lq_empty),
    .full  (lq_full),
    .count (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      we        <= 1'b0;
      write_reg <= '0;
      RF_HL     <= 1'b0;
      data_in   <= '0;
    end else begin
      we <= alu_valid || lq_pop;
      if (alu_valid) begin
        write_reg <= alu_rd;
        RF_HL     <= alu_hl;
        data_in   <= alu_data;
      end else if (lq_pop) begin
        write_reg <= head.rd;
        RF_HL     <= head.hl;
        data_in   <= head.data;
      end
    end
  end

  // Set is written last so a new issue wins over a same-cycle retirement.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      if (lq_pop)    pend[{head.hl, head.rd}] <= 1'b0;
      if (iss_valid) pend[{iss_hl, iss_rd}]   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: queue-based reference model compared every cycle, plus directed literal checks.
module tb_wb_unit;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int LQD = 2;

  logic          clk;
  logic          reset;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic          alu_hl;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic [AW-1:0] ld_rd;
  logic          ld_hl;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          iss_hl;
  logic          we;
  logic [AW-1:0] write_reg;
  logic          RF_HL;
  logic [DW-1:0] data_in;
  logic [31:0]   pend;
  logic [1:0]    lq_cnt;

  wb_unit #(.DW(DW), .AW(AW), .LQ_DEPTH(LQD)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_hl(alu_hl), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_hl(ld_hl), .ld_data(ld_data), .ld_ready(ld_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_hl(iss_hl),
    .we(we), .write_reg(write_reg), .RF_HL(RF_HL), .data_in(data_in),
    .pend(pend), .lq_cnt(lq_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of load records and a pending bit array.
  typedef struct {
    logic [AW-1:0] rd;
    logic          hl;
    logic [DW-1:0] data;
  } rec_t;

  rec_t          mq[$];
  logic [31:0]   m_pend;
  logic          m_we;
  logic [AW-1:0] m_rd;
  logic          m_hl;
  logic [DW-1:0] m_data;
  bit            m_live = 1'b0;

  always @(posedge clk) begin
    int   n;
    bit   rdy;
    rec_t r;
    if (reset) begin
      mq.delete();
      m_pend = '0;
      m_we   = 1'b0;
      m_rd   = '0;
      m_hl   = 1'b0;
      m_data = '0;
      m_live = 1'b1;
    end else if (m_live) begin
      n   = mq.size();
      rdy = (n < LQD) || (!alu_valid && n > 0);
      if (alu_valid) begin
        m_we = 1'b1; m_rd = alu_rd; m_hl = alu_hl; m_data = alu_data;
      end else if (n > 0) begin
        r = mq.pop_front();
        m_we = 1'b1; m_rd = r.rd; m_hl = r.hl; m_data = r.data;
        m_pend[{r.hl, r.rd}] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (ld_valid && rdy) mq.push_back('{ld_rd, ld_hl, ld_data});
      if (iss_valid) m_pend[{iss_hl, iss_rd}] = 1'b1;
    end
  end

  always @(negedge clk) begin
    int n;
    bit rdy;
    if (m_live) begin
      n   = mq.size();
      rdy = (n < LQD) || (!alu_valid && n > 0);
      chk("we", we, m_we);
      if (m_we) begin
        chk("write_reg", write_reg, m_rd);
        chk("RF_HL", RF_HL, m_hl);
        chk("data_in", data_in, m_data);
      end
      chk("pend", pend, m_pend);
      chk("lq_cnt", lq_cnt, n);
      chk("ld_ready", ld_ready, rdy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_hl = 0; alu_data = '0;
    ld_valid  = 0; ld_rd  = '0; ld_hl  = 0; ld_data  = '0;
    iss_valid = 0; iss_rd = '0; iss_hl = 0;
  endtask

  logic [AW-1:0] bp_rd   [3] = '{4'd10, 4'd11, 4'd12};
  logic [DW-1:0] bp_data [3] = '{32'h33333333, 32'h44444444, 32'h55555555};

  initial begin
    int            idx;
    bit            acc;
    int            nw;
    logic [AW-1:0] got [3];

    idle();
    reset = 1;
    step();
    step();
    chk("rst_we", we, 0);
    chk("rst_pend", pend, 0);
    chk("rst_lq_cnt", lq_cnt, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_rf_hl", RF_HL, 0);
    chk("rst_data_in", data_in, 0);
    reset = 0;
    step();

    // ALU-only write
    alu_valid = 1; alu_rd = 4'd1; alu_hl = 0; alu_data = 32'hFFFFFFFF;
    step();
    idle();
    chk("alu_we", we, 1);
    chk("alu_write_reg", write_reg, 1);
    chk("alu_rf_hl", RF_HL, 0);
    chk("alu_data_in", data_in, 32'hFFFFFFFF);
    step();

    // Issue then return
    iss_valid = 1; iss_rd = 4'd9; iss_hl = 1;
    step();
    idle();
    chk("iss_pend25_set", pend[25], 1);
    ld_valid = 1; ld_rd = 4'd9; ld_hl = 1; ld_data = 32'hAAAAAAAA;
    #1;
    chk("ret_ld_ready", ld_ready, 1);
    step();
    idle();
    chk("ret_we_after1", we, 0);
    chk("ret_lq_cnt1", lq_cnt, 1);
    step();
    chk("ret_we", we, 1);
    chk("ret_write_reg", write_reg, 9);
    chk("ret_rf_hl", RF_HL, 1);
    chk("ret_data_in", data_in, 32'hAAAAAAAA);
    chk("ret_pend25_clr", pend[25], 0);
    chk("ret_lq_cnt0", lq_cnt, 0);
    step();

    // Collision: ALU first, load one cycle later
    alu_valid = 1; alu_rd = 4'd2; alu_data = 32'h11111111;
    ld_valid  = 1; ld_rd  = 4'd3; ld_data  = 32'h22222222;
    step();
    idle();
    chk("col_alu_reg", write_reg, 2);
    chk("col_alu_data", data_in, 32'h11111111);
    step();
    chk("col_ld_we", we, 1);
    chk("col_ld_reg", write_reg, 3);
    chk("col_ld_data", data_in, 32'h22222222);
    step();

    // Back-pressure: 4 ALU cycles while offering 3 loads
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      alu_valid = 1; alu_rd = 4'(4 + c); alu_data = 32'hA0 + 32'(c);
      ld_valid  = (idx < 3);
      if (idx < 3) begin ld_rd = bp_rd[idx]; ld_data = bp_data[idx]; end
      #1;
      if (c == 2) chk("bp_ready_full", ld_ready, 0);
      acc = ld_valid && ld_ready;
      step();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 2);
    alu_valid = 0;
    ld_valid  = 1; ld_rd = bp_rd[2]; ld_data = bp_data[2];
    #1;
    chk("bp_ready_drain", ld_ready, 1);
    step();
    idle();
    nw = 0;
    got = '{default: '0};
    for (int k = 0; k < 5; k++) begin
      if (we && nw < 3) begin got[nw] = write_reg; nw++; end
      step();
    end
    chk("bp_nwrites", nw, 3);
    chk("bp_order0", got[0], 10);
    chk("bp_order1", got[1], 11);
    chk("bp_order2", got[2], 12);

    // Set/clear race on pend[5]
    iss_valid = 1; iss_rd = 4'd5; iss_hl = 0;
    step();
    idle();
    chk("race_pend5_set", pend[5], 1);
    ld_valid = 1; ld_rd = 4'd5; ld_hl = 0; ld_data = 32'h66666666;
    step();
    idle();
    iss_valid = 1; iss_rd = 4'd5; iss_hl = 0;
    step();
    idle();
    chk("race_we", we, 1);
    chk("race_write_reg", write_reg, 5);
    chk("race_pend5_kept", pend[5], 1);
    step();
    chk("race_pend5_later", pend[5], 1);

    // Reset mid-operation discards queued loads and pend bits
    alu_valid = 1; alu_rd = 4'd0; alu_data = 32'h77777777;
    ld_valid  = 1; ld_rd  = 4'd13; ld_hl = 1; ld_data = 32'h88888888;
    iss_valid = 1; iss_rd = 4'd13; iss_hl = 1;
    step();
    ld_rd = 4'd14; ld_data = 32'h99999999; iss_rd = 4'd14;
    step();
    idle();
    chk("mid_lq_full", lq_cnt, 2);
    chk("mid_pend29", pend[29], 1);
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_lq_cnt", lq_cnt, 0);
    chk("mid_rst_pend", pend, 0);
    step();
    chk("mid_post_we1", we, 0);
    step();
    chk("mid_post_we2", we, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 Parameter DW, default 32, register data width.
REQ-002 Parameter AW, default 4, register address width (16 registers per bank).
REQ-003 Parameter LQ_DEPTH, default 2, load-return queue depth.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 alu_valid / alu_rd / alu_hl / alu_data  in  1/AW/1/DW  ALU result; no backpressure, always accepted.
REQ-007 ld_valid / ld_rd / ld_hl / ld_data  in  1/AW/1/DW  load-return result.
REQ-008 ld_ready  out  1  load-return handshake; a transfer occurs when ld_valid and ld_ready are both 1.
REQ-009 iss_valid / iss_rd / iss_hl  in  1/AW/1  load issued; marks the destination register pending.
REQ-010 we / write_reg / RF_HL / data_in  out  1/AW/1/DW  registered write port driving the register file.
REQ-011 pend  out  2*2^AW  scoreboard; bit {hl,rd} = 1 while a load to that register is outstanding.
REQ-012 lq_cnt  out  2  current load-queue occupancy.

Function
REQ-013 Each cycle the unit SHALL select at most one write: the ALU if alu_valid, else the load-queue head if the queue is non-empty.
REQ-014 The selected write SHALL appear on we/write_reg/RF_HL/data_in exactly one cycle after selection; we=0 when nothing is selected.
REQ-015 Load returns SHALL be accepted into the FIFO load queue and written in arrival order, never reordered.
REQ-016 ld_ready SHALL be 1 when lq_cnt < LQ_DEPTH, or when the queue is full and the head drains this cycle (no alu_valid).
REQ-017 A load arriving at an empty queue with alu_valid=0 SHALL still pass through the queue (minimum load latency: 2 cycles from handshake to we).
REQ-018 Simultaneous enqueue and dequeue SHALL leave lq_cnt unchanged; lq_cnt SHALL never exceed LQ_DEPTH or underflow.
REQ-019 iss_valid SHALL set pend[{iss_hl,iss_rd}] at the next edge.
REQ-020 Dequeue of a load to {hl,rd} SHALL clear pend[{hl,rd}] in the same edge that registers the RF write.
REQ-021 When a set and a clear hit the same pend bit in one cycle, the set SHALL win.
REQ-022 The unit SHALL NOT check ALU writes against pend; upstream stalls on pend (WAW hazard is its responsibility).
REQ-023 Sustained alu_valid SHALL starve the queue indefinitely; ld_ready then falls once the queue is full.

Reset
REQ-024 While reset=1 at an edge: we=0, write_reg=0, RF_HL=0, data_in=0, pend=0, lq_cnt=0, queue pointers=0; ld_ready=1 on the first cycle after reset.
REQ-025 Reset mid-operation SHALL discard queued loads and outstanding pend bits without issuing any write.

Structure
REQ-026 DW, AW, and the write-request record {rd, hl, data} SHALL reside in the shared CPU package used by RF and wb_unit.
REQ-027 The load queue SHALL be a sub-module wb_lq (parameterised synchronous FIFO with count output); arbitration and scoreboard SHALL stay in wb_unit.

Verification
REQ-028 Reset: assert reset 2 cycles -> we=0, pend=0, lq_cnt=0, ld_ready=1.
REQ-029 ALU only: alu_valid, rd=1, hl=0, data=FFFFFFFF -> next cycle we=1, write_reg=1, RF_HL=0, data_in=FFFFFFFF.
REQ-030 Issue then return: iss rd=9, hl=1 -> pend[25]=1; ld rd=9, hl=1, data=AAAAAAAA -> two cycles later write to 9/hl=1, pend[25]=0.
REQ-031 Collision: ALU (rd=2, 11111111) and load (rd=3, 22222222) in the same cycle -> ALU write on cycle+1, load write on cycle+2.
REQ-032 Back-pressure: hold alu_valid 4 cycles while offering 3 loads -> ld_ready=0 after 2 accepted; loads are written in order once alu_valid drops.
REQ-033 Set/clear race: iss to rd=5 in the same cycle as the queued load to rd=5 dequeues -> write occurs and pend[5] stays 1.
